// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-fetch request controller: issues word fetches on the instruction
// bus, tracks outstanding transactions and forwards responses into the fetch FIFO.
module ibex_fetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         branch_addr_i,
    output logic                busy_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i,
    output logic                fifo_clear_o,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o
);

    localparam int unsigned CNT_W  = $clog2(2 * NUM_REQS + 1);
    localparam int unsigned WORD_W = 30;

    logic [WORD_W-1:0]   fetch_addr_q, fetch_addr_d;
    logic                held_q, held_d;
    logic [WORD_W-1:0]   held_addr_q, held_addr_d;
    logic                held_disc_q, held_disc_d;
    logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
    logic [NUM_REQS-1:0] discard_q, discard_d;

    logic [CNT_W-1:0]    pop_busy, pop_out, pop_sum;
    logic                space;
    logic                new_req;
    logic [WORD_W-1:0]   branch_word, req_word;
    logic                gnt_fire, tgt_gnt, new_disc, rsp;
    logic [NUM_REQS-1:0] out_s, disc_s;

    function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_REQS-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    // Request issue, address selection and grant/response qualification
    always_comb begin
        pop_busy    = popcnt(fifo_busy_i);
        pop_out     = popcnt(outstanding_q);
        pop_sum     = pop_busy + pop_out;
        space       = branch_i ? (pop_out < CNT_W'(NUM_REQS)) : (pop_sum < CNT_W'(NUM_REQS));
        branch_word = branch_addr_i[31:2];
        new_req     = req_i & ~held_q & ~outstanding_q[NUM_REQS-1] & (space | branch_i);
        req_word    = held_q ? held_addr_q : (branch_i ? branch_word : fetch_addr_q);
        gnt_fire    = (new_req | held_q) & instr_gnt_i;
        tgt_gnt     = gnt_fire & branch_i & (req_word == branch_word);
        // A held request overtaken by an earlier branch is stale even if granted later
        new_disc    = branch_i ? ~tgt_gnt : (held_q & held_disc_q);
        rsp         = instr_rvalid_i & outstanding_q[0];
    end

    assign instr_req_o  = new_req | held_q;
    assign instr_addr_o = {req_word, 2'b00};
    assign busy_o       = held_q | outstanding_q[0];
    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = branch_addr_i;
    assign fifo_valid_o = rsp & ~discard_q[0];
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;

    // Next-state: held request, outstanding/discard thermometers, fetch pointer
    always_comb begin
        held_d       = instr_req_o & ~instr_gnt_i;
        held_addr_d  = held_addr_q;
        held_disc_d  = held_d & held_q & (held_disc_q | branch_i);
        out_s        = outstanding_q;
        disc_s       = discard_q;
        fetch_addr_d = fetch_addr_q;

        if (instr_req_o && !held_q) begin
            held_addr_d = req_word;
        end

        if (rsp) begin
            out_s  = outstanding_q >> 1;
            disc_s = discard_q >> 1;
        end
        if (branch_i) begin
            disc_s = out_s;
        end

        outstanding_d = out_s;
        discard_d     = disc_s;
        if (gnt_fire) begin
            outstanding_d = {out_s[NUM_REQS-2:0], 1'b1};
            if (new_disc) begin
                discard_d = disc_s | (outstanding_d & ~out_s);
            end
        end

        if (branch_i && !tgt_gnt) begin
            fetch_addr_d = branch_word;
        end else if (gnt_fire && !new_disc) begin
            fetch_addr_d = req_word + WORD_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q  <= '0;
            held_q        <= 1'b0;
            held_addr_q   <= '0;
            held_disc_q   <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            held_q        <= held_d;
            held_addr_q   <= held_addr_d;
            held_disc_q   <= held_disc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Directed bench for ibex_fetch_req_ctrl.
module tb_ibex_fetch_req_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        busy_o;
    logic        instr_req_o;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        fifo_clear_o;
    logic [1:0]  fifo_busy_i;
    logic        fifo_valid_o;
    logic [31:0] fifo_addr_o;
    logic [31:0] fifo_rdata_o;
    logic        fifo_err_o;

    int checks = 0;
    int errors = 0;

    ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .busy_o         (busy_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .fifo_clear_o   (fifo_clear_o),
        .fifo_busy_i    (fifo_busy_i),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_err_o     (fifo_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_i = 1'b0; branch_i = 1'b0; instr_gnt_i = 1'b0;
        instr_rvalid_i = 1'b0; instr_err_i = 1'b0; fifo_busy_i = 2'b00;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", instr_req_o); end
        checks++; if (instr_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", instr_addr_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (fifo_valid_o !== 1'b0) begin errors++; $display("FAIL reset_fifo_valid: got %b expected 0", fifo_valid_o); end
        checks++; if (fifo_clear_o !== 1'b0) begin errors++; $display("FAIL reset_fifo_clear: got %b expected 0", fifo_clear_o); end
    endtask

    task automatic test_stream();
        rst_ni = 1'b1;
        req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h100; instr_gnt_i = 1'b1;
        #1;
        checks++; if (instr_req_o !== 1'b1) begin errors++; $display("FAIL stream_req0: got %b expected 1", instr_req_o); end
        checks++; if (instr_addr_o !== 32'h100) begin errors++; $display("FAIL stream_addr0: got %h expected 00000100", instr_addr_o); end
        checks++; if (fifo_clear_o !== 1'b1) begin errors++; $display("FAIL stream_clear: got %b expected 1", fifo_clear_o); end
        step();
        branch_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hA0000100;
        #1;
        checks++; if (instr_addr_o !== 32'h104) begin errors++; $display("FAIL stream_addr1: got %h expected 00000104", instr_addr_o); end
        checks++; if (fifo_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid1: got %b expected 1", fifo_valid_o); end
        checks++; if (fifo_rdata_o !== 32'hA0000100) begin errors++; $display("FAIL stream_rdata1: got %h expected a0000100", fifo_rdata_o); end
        step();
        instr_rdata_i = 32'hA0000104;
        #1;
        checks++; if (instr_addr_o !== 32'h108) begin errors++; $display("FAIL stream_addr2: got %h expected 00000108", instr_addr_o); end
        checks++; if (fifo_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid2: got %b expected 1", fifo_valid_o); end
        step();
        req_i = 1'b0; instr_gnt_i = 1'b0; instr_rdata_i = 32'hA0000108;
        #1;
        checks++; if (fifo_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid3: got %b expected 1", fifo_valid_o); end
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL stream_req_off: got %b expected 0", instr_req_o); end
        step();
        instr_rvalid_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL stream_busy_end: got %b expected 0", busy_o); end
    endtask

    task automatic test_branch_outstanding();
        req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h200; instr_gnt_i = 1'b1;
        step();
        branch_i = 1'b0;
        #1;
        checks++; if (instr_addr_o !== 32'h204) begin errors++; $display("FAIL bo_addr_204: got %h expected 00000204", instr_addr_o); end
        step();
        branch_i = 1'b1; branch_addr_i = 32'h302; instr_gnt_i = 1'b0;
        #1;
        checks++; if (fifo_clear_o !== 1'b1) begin errors++; $display("FAIL bo_clear: got %b expected 1", fifo_clear_o); end
        checks++; if (instr_addr_o !== 32'h300) begin errors++; $display("FAIL bo_addr_300: got %h expected 00000300", instr_addr_o); end
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL bo_req_full: got %b expected 0", instr_req_o); end
        checks++; if (fifo_addr_o !== 32'h302) begin errors++; $display("FAIL bo_fifo_addr: got %h expected 00000302", fifo_addr_o); end
        step();
        branch_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hB0000200;
        #1;
        checks++; if (fifo_valid_o !== 1'b0) begin errors++; $display("FAIL bo_drop_200: got %b expected 0", fifo_valid_o); end
        step();
        instr_gnt_i = 1'b1; instr_rdata_i = 32'hB0000204;
        #1;
        checks++; if (instr_addr_o !== 32'h300 || instr_req_o !== 1'b1) begin errors++; $display("FAIL bo_req_300: got req %b addr %h expected req 1 addr 00000300", instr_req_o, instr_addr_o); end
        checks++; if (fifo_valid_o !== 1'b0) begin errors++; $display("FAIL bo_drop_204: got %b expected 0", fifo_valid_o); end
        step();
        req_i = 1'b0; instr_gnt_i = 1'b0; instr_rdata_i = 32'hB0000300;
        #1;
        checks++; if (fifo_valid_o !== 1'b1) begin errors++; $display("FAIL bo_keep_300: got %b expected 1", fifo_valid_o); end
        step();
        instr_rvalid_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL bo_busy_end: got %b expected 0", busy_o); end
    endtask

    task automatic test_held_across_branch();
        req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h400; instr_gnt_i = 1'b0;
        #1;
        checks++; if (instr_addr_o !== 32'h400) begin errors++; $display("FAIL held_c1_addr: got %h expected 00000400", instr_addr_o); end
        step();
        branch_addr_i = 32'h500;
        #1;
        checks++; if (instr_addr_o !== 32'h400 || instr_req_o !== 1'b1) begin errors++; $display("FAIL held_c2: got req %b addr %h expected req 1 addr 00000400", instr_req_o, instr_addr_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL held_busy: got %b expected 1", busy_o); end
        step();
        branch_i = 1'b0; instr_gnt_i = 1'b1;
        #1;
        checks++; if (instr_addr_o !== 32'h400 || instr_req_o !== 1'b1) begin errors++; $display("FAIL held_c3: got req %b addr %h expected req 1 addr 00000400", instr_req_o, instr_addr_o); end
        step();
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'hC0000400;
        #1;
        checks++; if (instr_addr_o !== 32'h500) begin errors++; $display("FAIL held_next_500: got %h expected 00000500", instr_addr_o); end
        checks++; if (fifo_valid_o !== 1'b0) begin errors++; $display("FAIL held_drop_400: got %b expected 0", fifo_valid_o); end
        step();
        req_i = 1'b0; instr_gnt_i = 1'b0; instr_rdata_i = 32'hC0000500;
        #1;
        checks++; if (fifo_valid_o !== 1'b1) begin errors++; $display("FAIL held_keep_500: got %b expected 1", fifo_valid_o); end
        step();
        instr_rvalid_i = 1'b0;
    endtask

    task automatic test_backpressure();
        req_i = 1'b1; fifo_busy_i = 2'b11;
        #1;
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL bp_full_fifo: got %b expected 0", instr_req_o); end
        fifo_busy_i = 2'b00; instr_gnt_i = 1'b1;
        #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h504) begin errors++; $display("FAIL bp_issue: got req %b addr %h expected req 1 addr 00000504", instr_req_o, instr_addr_o); end
        step();
        instr_gnt_i = 1'b0; fifo_busy_i = 2'b01;
        #1;
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL bp_one_plus_one: got %b expected 0", instr_req_o); end
        fifo_busy_i = 2'b00;
        #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h508) begin errors++; $display("FAIL bp_space: got req %b addr %h expected req 1 addr 00000508", instr_req_o, instr_addr_o); end
        req_i = 1'b0; instr_rvalid_i = 1'b1;
        step();
        instr_rvalid_i = 1'b0;
    endtask

    task automatic test_error();
        req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h600; instr_gnt_i = 1'b1;
        step();
        branch_i = 1'b0; instr_rvalid_i = 1'b1; instr_err_i = 1'b1; instr_rdata_i = 32'hDEAD0600;
        #1;
        checks++; if (fifo_err_o !== 1'b1 || fifo_valid_o !== 1'b1) begin errors++; $display("FAIL err_fwd: got err %b valid %b expected 1 1", fifo_err_o, fifo_valid_o); end
        checks++; if (instr_addr_o !== 32'h604 || instr_req_o !== 1'b1) begin errors++; $display("FAIL err_next: got req %b addr %h expected req 1 addr 00000604", instr_req_o, instr_addr_o); end
        step();
        req_i = 1'b0; instr_gnt_i = 1'b0; instr_err_i = 1'b0;
        #1;
        checks++; if (fifo_valid_o !== 1'b1 || fifo_err_o !== 1'b0) begin errors++; $display("FAIL err_after: got valid %b err %b expected 1 0", fifo_valid_o, fifo_err_o); end
        step();
        instr_rvalid_i = 1'b0;
    endtask

    task automatic test_wrap_reset();
        req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'hFFFFFFFC; instr_gnt_i = 1'b1;
        #1;
        checks++; if (instr_addr_o !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_addr: got %h expected fffffffc", instr_addr_o); end
        step();
        req_i = 1'b0; branch_i = 1'b0; instr_gnt_i = 1'b0;
        #1;
        checks++; if (instr_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h expected 00000000", instr_addr_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL wrap_busy: got %b expected 1", busy_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
        step();
        rst_ni = 1'b1; instr_rvalid_i = 1'b1;
        #1;
        checks++; if (fifo_valid_o !== 1'b0) begin errors++; $display("FAIL late_rvalid: got %b expected 0", fifo_valid_o); end
        step();
        instr_rvalid_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL late_busy: got %b expected 0", busy_o); end
    endtask

    initial begin
        rst_ni = 1'b0;
        branch_addr_i = 32'h0;
        instr_rdata_i = 32'h0;
        idle_inputs();
        repeat (3) @(posedge clk_i);
        #1;
        test_reset();
        test_stream();
        idle_inputs();
        test_branch_outstanding();
        idle_inputs();
        test_held_across_branch();
        idle_inputs();
        test_backpressure();
        idle_inputs();
        test_error();
        idle_inputs();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_fetch_req_ctrl.md
# ibex_fetch_req_ctrl

Issues instruction-fetch requests on the 32-bit instruction bus and writes the returned words into `ibex_fetch_fifo`, which sits downstream of it. It holds the word-aligned fetch address and tracks up to NUM_REQS outstanding bus transactions. On a branch it clears the FIFO and drops stale responses. It throttles new requests against the FIFO fill level (`busy`) so a pushed word always finds a free entry.

## Interface

Parameters:
- NUM_REQS, 2, maximum outstanding bus requests; must equal the FIFO's NUM_REQS.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_i  in  1  fetch enable from IF stage
- branch_i  in  1  redirect this cycle
- branch_addr_i  in  32  redirect target (halfword aligned)
- busy_o  out  1  request held or any response outstanding
- instr_req_o  out  1  bus request
- instr_gnt_i  in  1  bus grant
- instr_addr_o  out  32  bus address, bits [1:0] always 0
- instr_rvalid_i  in  1  bus response valid
- instr_rdata_i  in  32  bus response data
- instr_err_i  in  1  bus response error
- fifo_clear_o  out  1  to FIFO clear_i
- fifo_busy_i  in  NUM_REQS  from FIFO busy_o
- fifo_valid_o  out  1  to FIFO in_valid_i
- fifo_addr_o  out  32  to FIFO in_addr_i
- fifo_rdata_o  out  32  to FIFO in_rdata_i
- fifo_err_o  out  1  to FIFO in_err_i

## Operation

- **State.**
  - fetch_addr_q[31:2]: next word to request.
  - held_q, held_addr_q: request asserted but not yet granted.
  - outstanding_q[NUM_REQS-1:0]: thermometer count of granted requests without a response.
  - discard_q[NUM_REQS-1:0]: parallel to outstanding_q; marks entries whose responses are dropped.
- **Space check.**
  - FIFO space exists when popcount(fifo_busy_i) + popcount(outstanding_q) < NUM_REQS.
  - On branch_i, the FIFO term is ignored because the FIFO is cleared.
- **New request.** Raised when:
  - req_i = 1, and
  - held_q = 0, and
  - outstanding_q[NUM_REQS-1] = 0, and
  - (space exists or branch_i = 1).
- **Request signals.**
  - instr_req_o = new request | held_q.
  - instr_addr_o = held_q ? held_addr_q : (branch_i ? {branch_addr_i[31:2],2'b00} : {fetch_addr_q,2'b00}).
- **Held request (bus protocol).**
  - Once instr_req_o = 1 without instr_gnt_i, held_q is set. instr_req_o and instr_addr_o stay constant until grant.
  - A held request is not withdrawn by branch_i or by req_i dropping.
- **Grant.**
  - The granted request enters outstanding_q at the next thermometer position.
  - Its discard bit = branch_i, unless the granted address is this cycle's branch word.
  - fetch_addr_q becomes granted word + 1.
- **Branch.**
  - fifo_clear_o = branch_i, combinationally.
  - fifo_addr_o = branch_addr_i when branch_i = 1, else don't-care (held at branch_addr_i).
  - All currently outstanding entries get discard = 1.
  - If the branch target was not granted this cycle, fetch_addr_q = branch_addr_i[31:2].
  - When a branch coincides with a grant of a held non-branch request, that request is discarded. fetch_addr_q takes the branch target, which is requested next.
- **Response.**
  - instr_rvalid_i retires the oldest outstanding entry; the thermometer shifts down by one.
  - fifo_valid_o = instr_rvalid_i & ~discard_q[0].
  - fifo_rdata_o = instr_rdata_i; fifo_err_o = instr_err_i.
  - Discarded responses produce no FIFO write.
- **Errors.** An error does not stop fetching; addresses keep incrementing.
- **Wrap-around.** Address arithmetic is mod 2^32: word 0x3FFFFFFF + 1 wraps to 0.
- **busy_o** = held_q | outstanding_q[0].
- **Unexpected response.** instr_rvalid_i with outstanding_q = 0 is ignored: no state change, fifo_valid_o = 0.

## Timing

- **Reset values.** All state is 0, so:
  - instr_req_o = 0, instr_addr_o = 0, busy_o = 0.
  - fifo_valid_o = 0, fifo_clear_o = 0 (when branch_i = 0).
- **Combinational paths.** instr_req_o and instr_addr_o are combinational from req_i/branch_i: a branch request issues in the same cycle as branch_i.
- **Response timing.** Responses arrive at least one cycle after their grant, in order. A grant and a response for an older request may occur in the same cycle.
- **Write latency.** FIFO write is zero-latency: fifo_valid_o is asserted in the instr_rvalid_i cycle.
- **Reset mid-transaction.** Outstanding state is dropped. Later responses are ignored, since outstanding_q = 0.
- **Simultaneous grant and branch.** The outstanding count includes the new grant before the branch-discard marking is applied, except the branch-target grant itself.

## Test plan

- **Reset then streaming.**
  - Stimulus: rst_ni released; req_i = 1; branch_i pulse to 0x100; gnt every cycle; rvalid 1 cycle after gnt.
  - Required: addresses 0x100, 0x104, 0x108; fifo_valid_o each response; never more than 2 outstanding.
- **Branch with outstanding requests.**
  - Stimulus: 2 requests outstanding (0x200, 0x204); branch_i to 0x302.
  - Required: fifo_clear_o = 1; instr_addr_o = 0x300 same cycle; responses for 0x200/0x204 give fifo_valid_o = 0; response for 0x300 gives fifo_valid_o = 1.
- **Held request across branch.**
  - Stimulus: req at 0x400 without gnt for 3 cycles; branch_i to 0x500 in cycle 2; gnt in cycle 3.
  - Required: address stays 0x400 through the grant; that response is discarded; next request is 0x500.
- **FIFO back-pressure.**
  - Stimulus: fifo_busy_i = 2'b11, outstanding 0.
  - Required: instr_req_o = 0. With fifo_busy_i = 2'b01 and 1 outstanding: instr_req_o = 0. With fifo_busy_i = 2'b00: instr_req_o = 1.
- **Error propagation.**
  - Stimulus: response with instr_err_i = 1 for 0x600.
  - Required: fifo_err_o = 1, fifo_valid_o = 1; next request is 0x604.
- **Wrap and reset mid-flight.**
  - Stimulus: branch to 0xFFFFFFFC; gnt.
  - Required: next address 0x00000000. Then assert rst_ni low with 1 outstanding: busy_o = 0 at once; a late rvalid gives fifo_valid_o = 0.
